led_dimmer: RTL and testbench

LED_DIMMER -- requirements
Module: led_dimmer

---
 rtl/led_dimmer_if.sv | 23 ++
 rtl/led_dimmer.sv | 122 ++++++++++++
 tb/tb_led_dimmer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/led_dimmer_if.sv
// LED dimmer bus: logical LED pattern, brightness writes and lamp-test control in,
// PWM pin drive and lamp-test status out.
interface led_dimmer_if #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned PWM_BITS = 8
);
    logic [WIDTH-1:0]    led_in;
    logic [PWM_BITS-1:0] brightness;
    logic                brightness_we;
    logic                lamp_test_req;
    logic [WIDTH-1:0]    led_pwm_out;
    logic                lamp_test_busy;

    modport master (
        output led_in, brightness, brightness_we, lamp_test_req,
        input  led_pwm_out, lamp_test_busy
    );

    modport slave (
        input  led_in, brightness, brightness_we, lamp_test_req,
        output led_pwm_out, lamp_test_busy
    );
endinterface

// File: rtl/led_dimmer.sv
// PWM brightness control of the LED pattern with period-aligned duty updates,
// plus a lamp test (all on, then a walking one across the channels).
module led_dimmer #(
    parameter int unsigned               WIDTH          = 16,
    parameter int unsigned               PWM_BITS       = 8,
    parameter logic [PWM_BITS-1:0]       BRIGHT_DEFAULT = 8'd128,
    parameter int unsigned               LT_ON_CYCLES   = 40079000,
    parameter int unsigned               LT_STEP_CYCLES = 4008000
) (
    input  logic         clock,
    input  logic         reset_n,
    led_dimmer_if.slave  bus
);
    localparam int unsigned LT_MAX = (LT_ON_CYCLES > LT_STEP_CYCLES) ? LT_ON_CYCLES : LT_STEP_CYCLES;
    localparam int unsigned DW     = (LT_MAX > 1) ? $clog2(LT_MAX + 1) : 1;
    localparam int unsigned SW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [DW-1:0]    ON_LAST   = DW'(LT_ON_CYCLES - 1);
    localparam logic [DW-1:0]    STEP_LAST = DW'(LT_STEP_CYCLES - 1);
    localparam logic [SW-1:0]    STEP_MAX  = SW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE_HOT0  = WIDTH'(1);

    typedef enum logic [1:0] {IDLE, ALL_ON, WALK} state_t;

    state_t              r_state, w_state_n;
    logic [DW-1:0]       r_dwell, w_dwell_n;
    logic [SW-1:0]       r_step,  w_step_n;
    logic [WIDTH-1:0]    r_led,   w_led_n;
    logic                r_busy;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [PWM_BITS-1:0] r_shadow;
    logic [PWM_BITS-1:0] r_bright_act;
    logic                w_wrap;
    logic                w_gate;

    assign w_wrap = (r_pwm_cnt == '1);
    assign w_gate = (r_bright_act == '1) || (r_pwm_cnt < r_bright_act);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pwm_cnt    <= '0;
            r_shadow     <= BRIGHT_DEFAULT;
            r_bright_act <= BRIGHT_DEFAULT;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
            if (bus.brightness_we)
                r_shadow <= bus.brightness;
            // A write landing on the wrap cycle must take effect in the very next period.
            if (w_wrap)
                r_bright_act <= bus.brightness_we ? bus.brightness : r_shadow;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_dwell <= '0;
            r_step  <= '0;
            r_led   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_dwell <= w_dwell_n;
            r_step  <= w_step_n;
            r_led   <= w_led_n;
            r_busy  <= (w_state_n != IDLE);
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_dwell_n = r_dwell;
        w_step_n  = r_step;
        w_led_n   = '0;
        case (r_state)
            IDLE: begin
                if (bus.lamp_test_req) begin
                    w_state_n = ALL_ON;
                    w_dwell_n = '0;
                    w_step_n  = '0;
                end
            end
            ALL_ON: begin
                if (r_dwell == ON_LAST) begin
                    w_state_n = WALK;
                    w_dwell_n = '0;
                    w_step_n  = '0;
                end else begin
                    w_dwell_n = r_dwell + DW'(1);
                end
            end
            WALK: begin
                if (r_dwell == STEP_LAST) begin
                    w_dwell_n = '0;
                    if (r_step == STEP_MAX) begin
                        w_state_n = IDLE;
                        w_step_n  = '0;
                    end else begin
                        w_step_n = r_step + SW'(1);
                    end
                end else begin
                    w_dwell_n = r_dwell + DW'(1);
                end
            end
            default: begin
                w_state_n = IDLE;
                w_dwell_n = '0;
                w_step_n  = '0;
            end
        endcase

        // Pin drive follows the next state so it changes on the same edge as the state.
        case (w_state_n)
            ALL_ON:  w_led_n = '1;
            WALK:    w_led_n = ONE_HOT0 << w_step_n;
            default: w_led_n = bus.led_in & {WIDTH{w_gate}};
        endcase
    end

    assign bus.led_pwm_out    = r_led;
    assign bus.lamp_test_busy = r_busy;
endmodule

// File: tb/tb_led_dimmer.sv
// Directed checks of PWM duty, period-aligned brightness updates, lamp test
// sequencing and asynchronous reset of led_dimmer.
module tb_led_dimmer;
    logic clock;
    logic reset_n;
    int   n_tests;
    int   n_fail;
    int   pk;

    led_dimmer_if #(.WIDTH(16), .PWM_BITS(8)) dif ();

    led_dimmer #(
        .WIDTH(16),
        .PWM_BITS(8),
        .BRIGHT_DEFAULT(8'd128),
        .LT_ON_CYCLES(5),
        .LT_STEP_CYCLES(3)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .bus(dif)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock; pk tracks the PWM count value used at the edge just taken.
    task automatic tick();
        @(posedge clock);
        @(negedge clock);
        pk = (pk + 1) % 256;
    endtask

    task automatic run_period(input logic [7:0] duty, input int wr_at, input logic [7:0] wr_val,
                              input logic [15:0] pat, input bit vary);
        logic [15:0] li;
        logic [15:0] exp;
        for (int k = 0; k < 256; k++) begin
            li = vary ? (pat ^ {8'(k), 8'(k)}) : pat;
            dif.led_in = li;
            if (k == wr_at) begin
                dif.brightness    = wr_val;
                dif.brightness_we = 1'b1;
            end
            tick();
            dif.brightness_we = 1'b0;
            exp = (duty == 8'hFF || k < int'(duty)) ? li : 16'h0000;
            check("pwm_out", 32'(dif.led_pwm_out), 32'(exp));
            check("busy_idle", 32'(dif.lamp_test_busy), 32'd0);
        end
    endtask

    task automatic lamp_prefix();
        dif.lamp_test_req = 1'b1;
        tick();
        dif.lamp_test_req = 1'b0;
        check("lt_busy_start", 32'(dif.lamp_test_busy), 32'd1);
        check("lt_allon", 32'(dif.led_pwm_out), 32'h0000FFFF);
        for (int c = 1; c < 5; c++) begin
            tick();
            check("lt_allon", 32'(dif.led_pwm_out), 32'h0000FFFF);
            check("lt_busy", 32'(dif.lamp_test_busy), 32'd1);
        end
    endtask

    initial begin
        logic [15:0] oh;
        n_tests = 0;
        n_fail  = 0;
        pk      = 0;
        reset_n = 1'b0;
        dif.led_in        = 16'hFFFF;
        dif.brightness    = 8'd0;
        dif.brightness_we = 1'b0;
        dif.lamp_test_req = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_out", 32'(dif.led_pwm_out), 32'd0);
        check("rst_busy", 32'(dif.lamp_test_busy), 32'd0);
        reset_n = 1'b1;
        pk = 0;

        run_period(8'd128, -1, 8'd0, 16'hFFFF, 1'b0);
        run_period(8'd128, 10, 8'd64, 16'hFFFF, 1'b0);
        run_period(8'd64, -1, 8'd0, 16'hFFFF, 1'b1);
        run_period(8'd64, 100, 8'd0, 16'hA5A5, 1'b0);
        run_period(8'd0, 255, 8'd32, 16'hA5A5, 1'b1);
        run_period(8'd32, 200, 8'hFF, 16'h3C3C, 1'b0);
        run_period(8'hFF, -1, 8'd0, 16'h3C3C, 1'b1);

        // Lamp test from a period boundary at full brightness.
        dif.led_in = 16'h1234;
        lamp_prefix();
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 3; j++) begin
                if (i == 5 && j == 1) dif.lamp_test_req = 1'b1;
                if (i == 7 && j == 0) begin
                    dif.brightness    = 8'd64;
                    dif.brightness_we = 1'b1;
                end
                tick();
                dif.lamp_test_req = 1'b0;
                dif.brightness_we = 1'b0;
                oh = 16'h0001 << i;
                check("lt_walk", 32'(dif.led_pwm_out), 32'(oh));
                check("lt_busy", 32'(dif.lamp_test_busy), 32'd1);
            end
        end
        tick();
        check("lt_end_busy", 32'(dif.lamp_test_busy), 32'd0);
        check("lt_end_out", 32'(dif.led_pwm_out), 32'h00001234);
        while (pk != 0) begin
            tick();
            check("post_lt_out", 32'(dif.led_pwm_out), 32'h00001234);
            check("busy_idle", 32'(dif.lamp_test_busy), 32'd0);
        end
        run_period(8'd64, -1, 8'd0, 16'hFFFF, 1'b0);

        // Reset asserted in the middle of the walk, away from any rising edge.
        dif.led_in = 16'hFFFF;
        lamp_prefix();
        repeat (10) tick();
        check("walk_before_rst", 32'(dif.led_pwm_out), 32'h00000008);
        #1 reset_n = 1'b0;
        #1;
        check("async_rst_out", 32'(dif.led_pwm_out), 32'd0);
        check("async_rst_busy", 32'(dif.lamp_test_busy), 32'd0);
        dif.lamp_test_req = 1'b1;
        dif.brightness    = 8'd16;
        dif.brightness_we = 1'b1;
        @(posedge clock);
        @(negedge clock);
        dif.lamp_test_req = 1'b0;
        dif.brightness_we = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_hold_out", 32'(dif.led_pwm_out), 32'd0);
        check("rst_hold_busy", 32'(dif.lamp_test_busy), 32'd0);
        reset_n = 1'b1;
        pk = 0;
        run_period(8'd128, -1, 8'd0, 16'hFFFF, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end
endmodule
